// File: rtl/pwm_test_pkg.sv
// Shared constants, sweep direction type and helpers for the servo PWM exerciser.
package pwm_test_pkg;

  localparam int unsigned DEF_CLK_HZ          = 50_000_000;
  localparam int unsigned DEF_MIN_PULSE_CYC   = 50_000;
  localparam int unsigned DEF_CYC_PER_DEG     = 277;
  localparam int unsigned DEF_MAX_DEG         = 180;
  localparam int unsigned DEF_STEP_DEG        = 1;
  localparam int unsigned DEF_FRAMES_PER_STEP = 1;
  localparam int unsigned DEF_N_CH            = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {DirUp, DirDown} dir_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Active-low segments, bit0 = a .. bit6 = g; non-BCD codes blank the digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// One BCD digit to an active-low 7-segment pattern.
module seven_seg_decoder
  import pwm_test_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_encode(bcd_i);
  end

endmodule

// File: rtl/pwm_test_top.sv
// Self-running servo exerciser: N_CH in-phase PWM channels sweeping a shared angle,
// with the angle shown in decimal on three 7-segment digits (fourth blank).
module pwm_test_top
  import pwm_test_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned PERIOD_CYC      = CLK_HZ / 50,
  parameter int unsigned MIN_PULSE_CYC   = DEF_MIN_PULSE_CYC,
  parameter int unsigned CYC_PER_DEG     = DEF_CYC_PER_DEG,
  parameter int unsigned MAX_DEG         = DEF_MAX_DEG,
  parameter int unsigned STEP_DEG        = DEF_STEP_DEG,
  parameter int unsigned FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
  parameter int unsigned N_CH            = DEF_N_CH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [3:0][6:0]       seven_seg_display,
  output logic [N_CH-1:0]       pwm_out
);

  localparam int unsigned FW = cnt_width(PERIOD_CYC);
  localparam int unsigned PW = cnt_width(PERIOD_CYC + 1);
  localparam int unsigned SW = cnt_width(FRAMES_PER_STEP + 1);

  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PW-1:0]   pulse_q, pulse_d, pulse_cyc;
  logic [7:0]      angle_q, angle_d;
  dir_e            dir_q, dir_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;
  logic [N_CH-1:0] pwm_q, pwm_d;
  logic            frame_wrap;

  assign frame_wrap = (frame_cnt_q == FW'(PERIOD_CYC - 1));
  assign pulse_cyc  = PW'(MIN_PULSE_CYC) + PW'(angle_q) * PW'(CYC_PER_DEG);

  always_comb begin
    frame_cnt_d = frame_cnt_q + FW'(1);
    pulse_d     = pulse_q;
    angle_d     = angle_q;
    dir_d       = dir_q;
    step_cnt_d  = step_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = '0;
      // Latch uses the pre-update angle, so a new angle takes effect one frame later.
      pulse_d     = pulse_cyc;
      if (step_cnt_q + SW'(1) >= SW'(FRAMES_PER_STEP)) begin
        step_cnt_d = '0;
        if (dir_q == DirUp) begin
          if ({1'b0, angle_q} + 9'(STEP_DEG) >= 9'(MAX_DEG)) begin
            angle_d = 8'(MAX_DEG);
            dir_d   = DirDown;
          end else begin
            angle_d = angle_q + 8'(STEP_DEG);
          end
        end else begin
          if (angle_q <= 8'(STEP_DEG)) begin
            angle_d = '0;
            dir_d   = DirUp;
          end else begin
            angle_d = angle_q - 8'(STEP_DEG);
          end
        end
      end else begin
        step_cnt_d = step_cnt_q + SW'(1);
      end
    end
  end

  always_comb begin
    pwm_d = (PW'(frame_cnt_q) < pulse_q) ? {N_CH{1'b1}} : {N_CH{1'b0}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      pulse_q     <= PW'(MIN_PULSE_CYC);
      angle_q     <= '0;
      dir_q       <= DirUp;
      step_cnt_q  <= '0;
      pwm_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pulse_q     <= pulse_d;
      angle_q     <= angle_d;
      dir_q       <= dir_d;
      step_cnt_q  <= step_cnt_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

  // Angle is at most 180, so one hundreds subtract and a tens search suffice.
  logic [7:0] rem;
  logic [3:0] hund, tens, ones;

  always_comb begin
    rem  = angle_q;
    hund = 4'd0;
    if (rem >= 8'd100) begin
      hund = 4'd1;
      rem  = rem - 8'd100;
    end
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (rem >= 8'(i * 10)) tens = 4'(i);
    end
    ones = 4'(rem - 8'(tens) * 8'd10);
  end

  logic [6:0] seg0, seg1, seg2;

  seven_seg_decoder u_dec0 (.bcd_i(ones), .seg_o(seg0));
  seven_seg_decoder u_dec1 (.bcd_i(tens), .seg_o(seg1));
  seven_seg_decoder u_dec2 (.bcd_i(hund), .seg_o(seg2));

  assign seven_seg_display = {SEG_BLANK, seg2, seg1, seg0};

endmodule

// File: tb/tb_pwm_test_top.sv
// Bench for pwm_test_top: a fast-parameter instance for sweep/display behaviour and a
// default-parameter instance for the real 1 ms first pulse.
module tb_pwm_test_top;

  localparam int NCH    = 5;
  localparam int PERIOD = 200;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rst_n_def;
  logic [3:0][6:0] seg, seg_def;
  logic [NCH-1:0]  pwm, pwm_def;

  always #5 clk = ~clk;

  pwm_test_top #(
    .PERIOD_CYC   (200),
    .MIN_PULSE_CYC(10),
    .CYC_PER_DEG  (1),
    .MAX_DEG      (180),
    .STEP_DEG     (60)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .seven_seg_display(seg),
    .pwm_out          (pwm)
  );

  pwm_test_top dut_def (
    .clk              (clk),
    .rst_n            (rst_n_def),
    .seven_seg_display(seg_def),
    .pwm_out          (pwm_def)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int high;
    int angle;
  } frame_t;

  frame_t vec[9];
  frame_t sb[$];

  function automatic logic [6:0] enc(input int d);
    logic [6:0] t[10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [31:0] disp(input int a);
    logic [3:0][6:0] r;
    r[3] = 7'h7F;
    r[2] = enc(a / 100);
    r[1] = enc((a / 10) % 10);
    r[0] = enc(a % 10);
    return 32'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Samples one full PWM frame of the fast instance and scores it against the queue head.
  task automatic run_frame(input string tag, output int highs);
    frame_t      e;
    int          h = 0;
    bit          low_seen = 0;
    bit          shape_bad = 0;
    logic [31:0] d0 = '0;
    for (int j = 0; j < PERIOD; j++) begin
      @(negedge clk);
      if (j == 0) d0 = 32'(seg);
      if (pwm != '0 && pwm != '1) shape_bad = 1;
      if (pwm[0]) begin
        if (low_seen) shape_bad = 1;
        h++;
      end else begin
        low_seen = 1;
      end
    end
    highs = h;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_high"}, 32'(h), 32'(e.high));
    check({tag, "_shape"}, 32'(shape_bad), 32'd0);
    check({tag, "_disp"}, d0, disp(e.angle));
  endtask

  initial begin
    int h;
    int n190;
    int n10;
    int errs;

    vec[0] = '{10, 0};
    vec[1] = '{10, 60};
    vec[2] = '{70, 120};
    vec[3] = '{130, 180};
    vec[4] = '{190, 120};
    vec[5] = '{130, 60};
    vec[6] = '{70, 0};
    vec[7] = '{10, 60};
    vec[8] = '{70, 120};

    rst_n     = 1'b0;
    rst_n_def = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_disp", 32'(seg), 32'({7'h7F, 7'h40, 7'h40, 7'h40}));
    rst_n = 1'b1;

    n190 = 0;
    n10  = 0;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(vec[i]);
      run_frame($sformatf("frame%0d", i), h);
      if (h == 190) n190++;
      if (i >= 2 && h == 10) n10++;
    end
    check("frames_at_180", 32'(n190), 32'd1);
    check("frames_at_0", 32'(n10), 32'd1);

    // Frame 9 pulses for 130 cycles; hit reset with frame_cnt=5 on the outputs.
    repeat (6) @(negedge clk);
    check("pre_reset_high", 32'(pwm), 32'h1F);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_pwm", 32'(pwm), 32'd0);
    check("midreset_disp", 32'(seg), disp(0));
    repeat (5) @(negedge clk);
    check("held_reset_pwm", 32'(pwm), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(vec[i]);
      run_frame($sformatf("restart%0d", i), h);
    end

    check("def_reset_pwm", 32'(pwm_def), 32'd0);
    check("def_reset_disp", 32'(seg_def), disp(0));
    rst_n_def = 1'b1;
    errs = 0;
    for (int j = 1; j <= 50_000; j++) begin
      @(negedge clk);
      if (pwm_def !== 5'h1F) errs++;
    end
    check("def_high_cycles_bad", 32'(errs), 32'd0);
    @(negedge clk);
    check("def_low_at_50001", 32'(pwm_def), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
